// File: rtl/multicycle_control_if.sv
// ---------------------------------------------------------------------------
// multicycle_control_if
// Bundles the sequencer's datapath-facing signals.
//   master : the controller (drives strobes/selects, receives instruction,
//            mem_ready and rs_neg)
//   slave  : the datapath / memory side (the mirror image)
// Signals:
//   instruction[31:0]  instruction register contents
//   mem_ready          memory access completes this cycle
//   rs_neg             bit 31 of rs read data
//   ir_wr, pc_wr       IR / PC load strobes
//   pc_src[1:0]        PC source select
//   i_or_d             memory address select (0 PC, 1 ALU)
//   mem_rd, mem_wr     memory read / write requests
//   reg_wr             register file write enable
//   reg_dst            write register select (1 rd, 0 rt)
//   mem_to_reg         write-back data select (1 memory, 0 ALU)
//   alu_src            ALU B select (1 immediate, 0 rt)
//   alu_cntrl[1:0]     ALU op: ADD/SUB/NOR/SLTU
//   halted, err[1:0]   halt flag and error code
//   retired[31:0]      completed instruction count
// ---------------------------------------------------------------------------
interface multicycle_control_if;
    logic [31:0] instruction;
    logic        mem_ready;
    logic        rs_neg;
    logic        ir_wr;
    logic        pc_wr;
    logic [1:0]  pc_src;
    logic        i_or_d;
    logic        mem_rd;
    logic        mem_wr;
    logic        reg_wr;
    logic        reg_dst;
    logic        mem_to_reg;
    logic        alu_src;
    logic [1:0]  alu_cntrl;
    logic        halted;
    logic [1:0]  err;
    logic [31:0] retired;

    modport master (
        input  instruction, mem_ready, rs_neg,
        output ir_wr, pc_wr, pc_src, i_or_d, mem_rd, mem_wr, reg_wr,
               reg_dst, mem_to_reg, alu_src, alu_cntrl, halted, err, retired
    );

    modport slave (
        output instruction, mem_ready, rs_neg,
        input  ir_wr, pc_wr, pc_src, i_or_d, mem_rd, mem_wr, reg_wr,
               reg_dst, mem_to_reg, alu_src, alu_cntrl, halted, err, retired
    );
endinterface

// File: rtl/multicycle_control.sv
// ---------------------------------------------------------------------------
// multicycle_control
// Multi-cycle instruction sequencer: FETCH -> DECODE -> EXEC -> MEM -> WB over
// a shared single-port memory, with a bounded wait on mem_ready.
// Ports:
//   clk    system clock, rising edge
//   reset  asynchronous active-high reset
//   bus    multicycle_control_if.master (instruction/handshake inputs,
//          datapath strobes, selects, status and retired count outputs)
// Parameters:
//   TIMEOUT  max cycles waiting for mem_ready in FETCH or MEM
//   CNT_W    wait counter width (must hold TIMEOUT)
// ---------------------------------------------------------------------------
module multicycle_control #(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 5
) (
    input  logic                clk,
    input  logic                reset,
    multicycle_control_if.master bus
);

    typedef enum logic [2:0] {
        S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT
    } state_t;

    typedef enum logic [2:0] {
        OP_NONE, OP_ADDI, OP_LW, OP_SW, OP_SUBU, OP_NOR, OP_SLTU
    } op_t;

    localparam logic [1:0] ALU_ADD  = 2'b00;
    localparam logic [1:0] ALU_SUB  = 2'b01;
    localparam logic [1:0] ALU_NOR  = 2'b10;
    localparam logic [1:0] ALU_SLTU = 2'b11;

    localparam logic [1:0] ERR_NONE    = 2'b00;
    localparam logic [1:0] ERR_ILLEGAL = 2'b01;
    localparam logic [1:0] ERR_TIMEOUT = 2'b10;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    state_t           state_q, state_d;
    op_t              op_q, op_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       err_q, err_d;
    logic [31:0]      retired_q;
    logic             retire;

    logic       ir_wr, pc_wr, mem_rd, mem_wr, reg_wr;
    logic [1:0] pc_src, alu_cntrl;
    logic       i_or_d, reg_dst, mem_to_reg, alu_src;

    logic [5:0] opcode, funct;
    op_t        dec_op;
    logic       is_j, is_jr, is_bltz;
    logic       unused_instr_bits;

    assign opcode = bus.instruction[31:26];
    assign funct  = bus.instruction[5:0];
    // Register/immediate fields are consumed by the datapath, not here.
    assign unused_instr_bits = ^bus.instruction[25:6];

    assign is_j    = (opcode == 6'b000010);
    assign is_jr   = (opcode == 6'b000000) && (funct == 6'b001000);
    assign is_bltz = (opcode == 6'b000001);

    // Ops that need EXEC. Note subu/lw and sltu/sw share codes, split by opcode==0.
    always_comb begin
        dec_op = OP_NONE;
        if (opcode == 6'b000000) begin
            case (funct)
                6'b100011: dec_op = OP_SUBU;
                6'b100111: dec_op = OP_NOR;
                6'b101011: dec_op = OP_SLTU;
                default:   dec_op = OP_NONE;
            endcase
        end else begin
            case (opcode)
                6'b001000: dec_op = OP_ADDI;
                6'b100011: dec_op = OP_LW;
                6'b101011: dec_op = OP_SW;
                default:   dec_op = OP_NONE;
            endcase
        end
    end

    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        cnt_d      = '0;
        err_d      = err_q;
        retire     = 1'b0;
        ir_wr      = 1'b0;
        pc_wr      = 1'b0;
        pc_src     = 2'b00;
        i_or_d     = 1'b0;
        mem_rd     = 1'b0;
        mem_wr     = 1'b0;
        reg_wr     = 1'b0;
        reg_dst    = 1'b0;
        mem_to_reg = 1'b0;
        alu_src    = 1'b0;
        alu_cntrl  = ALU_ADD;

        case (state_q)
            S_FETCH: begin
                mem_rd = 1'b1;
                if (bus.mem_ready) begin
                    ir_wr   = 1'b1;
                    pc_wr   = 1'b1;
                    state_d = S_DECODE;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = S_HALT;
                    err_d   = ERR_TIMEOUT;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            S_DECODE: begin
                op_d = dec_op;
                if (is_j) begin
                    pc_wr   = 1'b1;
                    pc_src  = 2'b10;
                    retire  = 1'b1;
                    state_d = S_FETCH;
                end else if (is_jr) begin
                    pc_wr   = 1'b1;
                    pc_src  = 2'b11;
                    retire  = 1'b1;
                    state_d = S_FETCH;
                end else if (is_bltz) begin
                    pc_wr   = bus.rs_neg;
                    pc_src  = 2'b01;
                    retire  = 1'b1;
                    state_d = S_FETCH;
                end else if (dec_op != OP_NONE) begin
                    state_d = S_EXEC;
                end else begin
                    state_d = S_HALT;
                    err_d   = ERR_ILLEGAL;
                end
            end

            S_EXEC: begin
                case (op_q)
                    OP_SUBU: begin alu_cntrl = ALU_SUB;  state_d = S_WB; end
                    OP_NOR:  begin alu_cntrl = ALU_NOR;  state_d = S_WB; end
                    OP_SLTU: begin alu_cntrl = ALU_SLTU; state_d = S_WB; end
                    OP_ADDI: begin alu_src = 1'b1; state_d = S_WB; end
                    OP_LW, OP_SW: begin alu_src = 1'b1; state_d = S_MEM; end
                    default: begin state_d = S_HALT; err_d = ERR_ILLEGAL; end
                endcase
            end

            S_MEM: begin
                i_or_d  = 1'b1;
                alu_src = 1'b1;
                mem_rd  = (op_q == OP_LW);
                mem_wr  = (op_q == OP_SW);
                if (bus.mem_ready) begin
                    if (op_q == OP_LW) begin
                        state_d = S_WB;
                    end else begin
                        retire  = 1'b1;
                        state_d = S_FETCH;
                    end
                end else if (cnt_q == CNT_LAST) begin
                    state_d = S_HALT;
                    err_d   = ERR_TIMEOUT;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            S_WB: begin
                reg_wr     = 1'b1;
                reg_dst    = (op_q == OP_SUBU) || (op_q == OP_NOR) || (op_q == OP_SLTU);
                mem_to_reg = (op_q == OP_LW);
                retire     = 1'b1;
                state_d    = S_FETCH;
            end

            S_HALT: begin
                state_d = S_HALT;
            end

            default: begin
                state_d = S_HALT;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= S_FETCH;
            op_q      <= OP_NONE;
            cnt_q     <= '0;
            err_q     <= ERR_NONE;
            retired_q <= '0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            cnt_q     <= cnt_d;
            err_q     <= err_d;
            retired_q <= retired_q + {31'd0, retire};
        end
    end

    // Reset is async, so the state already reads FETCH while reset is high;
    // gating the strobes keeps FETCH's read request (and any write) off too.
    assign bus.ir_wr      = ir_wr  & ~reset;
    assign bus.pc_wr      = pc_wr  & ~reset;
    assign bus.mem_rd     = mem_rd & ~reset;
    assign bus.mem_wr     = mem_wr & ~reset;
    assign bus.reg_wr     = reg_wr & ~reset;
    assign bus.pc_src     = pc_src;
    assign bus.i_or_d     = i_or_d;
    assign bus.reg_dst    = reg_dst;
    assign bus.mem_to_reg = mem_to_reg;
    assign bus.alu_src    = alu_src;
    assign bus.alu_cntrl  = alu_cntrl;
    assign bus.halted     = (state_q == S_HALT);
    assign bus.err        = err_q;
    assign bus.retired    = retired_q;

endmodule

// File: tb/tb_multicycle_control.sv
// ---------------------------------------------------------------------------
// tb_multicycle_control
// Directed bench for multicycle_control. Output vector order used below:
// {ir_wr, pc_wr, pc_src[1:0], i_or_d, mem_rd, mem_wr, reg_wr, reg_dst,
//  mem_to_reg, alu_src, alu_cntrl[1:0], halted, err[1:0]}
// ---------------------------------------------------------------------------
module tb_multicycle_control;
    logic clk = 1'b0;
    logic reset;
    int   ntests = 0;
    int   nfail  = 0;

    multicycle_control_if bus();

    multicycle_control #(.TIMEOUT(16), .CNT_W(5)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    localparam logic [15:0] V_IDLE      = 16'b0_0_00_0_0_0_0_0_0_0_00_0_00;
    localparam logic [15:0] V_FETCH_ACK = 16'b1_1_00_0_1_0_0_0_0_0_00_0_00;
    localparam logic [15:0] V_FETCH_WT  = 16'b0_0_00_0_1_0_0_0_0_0_00_0_00;
    localparam logic [15:0] V_EXEC_I    = 16'b0_0_00_0_0_0_0_0_0_1_00_0_00;
    localparam logic [15:0] V_EXEC_SUB  = 16'b0_0_00_0_0_0_0_0_0_0_01_0_00;
    localparam logic [15:0] V_EXEC_NOR  = 16'b0_0_00_0_0_0_0_0_0_0_10_0_00;
    localparam logic [15:0] V_EXEC_SLT  = 16'b0_0_00_0_0_0_0_0_0_0_11_0_00;
    localparam logic [15:0] V_MEM_LW    = 16'b0_0_00_1_1_0_0_0_0_1_00_0_00;
    localparam logic [15:0] V_MEM_SW    = 16'b0_0_00_1_0_1_0_0_0_1_00_0_00;
    localparam logic [15:0] V_WB_I      = 16'b0_0_00_0_0_0_1_0_0_0_00_0_00;
    localparam logic [15:0] V_WB_LW     = 16'b0_0_00_0_0_0_1_0_1_0_00_0_00;
    localparam logic [15:0] V_WB_R      = 16'b0_0_00_0_0_0_1_1_0_0_00_0_00;
    localparam logic [15:0] V_DEC_J     = 16'b0_1_10_0_0_0_0_0_0_0_00_0_00;
    localparam logic [15:0] V_DEC_JR    = 16'b0_1_11_0_0_0_0_0_0_0_00_0_00;
    localparam logic [15:0] V_DEC_BN    = 16'b0_0_01_0_0_0_0_0_0_0_00_0_00;
    localparam logic [15:0] V_DEC_BT    = 16'b0_1_01_0_0_0_0_0_0_0_00_0_00;
    localparam logic [15:0] V_HALT_ILL  = 16'b0_0_00_0_0_0_0_0_0_0_00_1_01;
    localparam logic [15:0] V_HALT_TO   = 16'b0_0_00_0_0_0_0_0_0_0_00_1_10;

    function automatic logic [15:0] outs();
        return {bus.ir_wr, bus.pc_wr, bus.pc_src, bus.i_or_d, bus.mem_rd,
                bus.mem_wr, bus.reg_wr, bus.reg_dst, bus.mem_to_reg,
                bus.alu_src, bus.alu_cntrl, bus.halted, bus.err};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ntests++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Check the outputs of the current cycle, then advance one clock.
    task automatic step(input string tag, input logic [15:0] exp);
        #1;
        chk(tag, {16'd0, outs()}, {16'd0, exp});
        tick();
    endtask

    task automatic fetch(input logic [31:0] instr);
        bus.instruction = instr;
        bus.mem_ready   = 1'b1;
        step("fetch", V_FETCH_ACK);
    endtask

    initial begin
        reset           = 1'b1;
        bus.instruction = 32'd0;
        bus.mem_ready   = 1'b0;
        bus.rs_neg      = 1'b0;
        tick();
        #1;
        chk("reset_outs", {16'd0, outs()}, {16'd0, V_IDLE});
        chk("reset_retired", bus.retired, 32'd0);
        tick();
        reset = 1'b0;

        // addi: FETCH, DECODE, EXEC, WB
        fetch(32'h2008_0005);
        step("addi_dec", V_IDLE);
        step("addi_exec", V_EXEC_I);
        step("addi_wb", V_WB_I);
        chk("addi_retired", bus.retired, 32'd1);

        // lw with three wait cycles in MEM
        fetch(32'h8C08_0004);
        step("lw_dec", V_IDLE);
        step("lw_exec", V_EXEC_I);
        bus.mem_ready = 1'b0;
        for (int i = 0; i < 3; i++) step("lw_mem_wait", V_MEM_LW);
        bus.mem_ready = 1'b1;
        step("lw_mem_done", V_MEM_LW);
        step("lw_wb", V_WB_LW);
        chk("lw_retired", bus.retired, 32'd2);

        // sw with one wait cycle; no WB
        fetch(32'hAC08_0004);
        step("sw_dec", V_IDLE);
        step("sw_exec", V_EXEC_I);
        bus.mem_ready = 1'b0;
        step("sw_mem_wait", V_MEM_SW);
        bus.mem_ready = 1'b1;
        step("sw_mem_done", V_MEM_SW);
        chk("sw_retired", bus.retired, 32'd3);
        #1;
        chk("sw_back_fetch", {16'd0, outs()}, {16'd0, V_FETCH_ACK});

        // R-type ALU ops
        fetch(32'h0109_5023);
        step("subu_dec", V_IDLE);
        step("subu_exec", V_EXEC_SUB);
        step("subu_wb", V_WB_R);
        fetch(32'h0109_5027);
        step("nor_dec", V_IDLE);
        step("nor_exec", V_EXEC_NOR);
        step("nor_wb", V_WB_R);
        fetch(32'h0109_502B);
        step("sltu_dec", V_IDLE);
        step("sltu_exec", V_EXEC_SLT);
        step("sltu_wb", V_WB_R);
        chk("rtype_retired", bus.retired, 32'd6);

        // Jumps and branches finish in DECODE
        fetch(32'h0800_0040);
        step("j_dec", V_DEC_J);
        fetch(32'h03E0_0008);
        step("jr_dec", V_DEC_JR);
        bus.rs_neg = 1'b0;
        fetch(32'h0500_FFFF);
        step("bltz_nt_dec", V_DEC_BN);
        bus.rs_neg = 1'b1;
        fetch(32'h0500_FFFF);
        step("bltz_t_dec", V_DEC_BT);
        bus.rs_neg = 1'b0;
        chk("branch_retired", bus.retired, 32'd10);

        // Reset in the middle of WB
        fetch(32'h2008_0005);
        step("mid_dec", V_IDLE);
        step("mid_exec", V_EXEC_I);
        #1;
        chk("mid_wb_before", {16'd0, outs()}, {16'd0, V_WB_I});
        reset = 1'b1;
        #1;
        chk("mid_reset_outs", {16'd0, outs()}, {16'd0, V_IDLE});
        chk("mid_reset_retired", bus.retired, 32'd0);
        tick();
        reset = 1'b0;
        #1;
        chk("post_reset_fetch", {16'd0, outs()}, {16'd0, V_FETCH_ACK});

        // mem_ready arrives in the 16th FETCH cycle: no timeout
        bus.instruction = 32'h0800_0040;
        bus.mem_ready   = 1'b0;
        for (int i = 0; i < 15; i++) step("to_edge_wait", V_FETCH_WT);
        bus.mem_ready = 1'b1;
        step("to_edge_ack", V_FETCH_ACK);
        step("to_edge_dec", V_DEC_J);
        chk("to_edge_retired", bus.retired, 32'd1);

        // 16 cycles with no mem_ready: timeout halt
        bus.mem_ready = 1'b0;
        for (int i = 0; i < 16; i++) step("to_wait", V_FETCH_WT);
        bus.mem_ready = 1'b1;
        step("to_halt", V_HALT_TO);
        step("to_halt_hold", V_HALT_TO);
        chk("to_retired", bus.retired, 32'd1);

        // Illegal opcode
        reset = 1'b1;
        tick();
        reset = 1'b0;
        fetch(32'hFC00_0000);
        step("ill_dec", V_IDLE);
        step("ill_halt", V_HALT_ILL);
        step("ill_halt_hold", V_HALT_ILL);
        chk("ill_retired", bus.retired, 32'd0);

        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end
endmodule
